// File: rtl/input_window_sched.sv
// rtl/input_window_sched.sv - KxK convolution window sweep over the input feature-map RAM
// Optional zero-border padding: define INPUT_WINDOW_PAD_EN.
module input_window_sched #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int K          = 3,
  parameter int STRIDE     = 1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  input  logic [DATA_WIDTH-1:0] ram_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [7:0]            win_row,
  output logic [7:0]            win_col
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

`ifdef INPUT_WINDOW_PAD_EN
  localparam int ORG = (K - 1) / 2;
  localparam int NR  = (IMG_H + STRIDE - 1) / STRIDE;
  localparam int NC  = (IMG_W + STRIDE - 1) / STRIDE;
`else
  localparam int ORG = 0;
  localparam int NR  = (IMG_H - K) / STRIDE + 1;
  localparam int NC  = (IMG_W - K) / STRIDE + 1;
`endif

  localparam logic [7:0] K_LAST  = 8'(K - 1);
  localparam logic [7:0] NR_LAST = 8'(NR - 1);
  localparam logic [7:0] NC_LAST = 8'(NC - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] base;
  logic [7:0]            wr, wc, kr, kc;
  logic                  all_loaded;
  logic                  load;
  logic                  final_tap;
  int                    row_pos;
  int                    col_pos;
  int                    lin;
  logic [ADDR_WIDTH-1:0] lin_addr;
  logic [DATA_WIDTH-1:0] tap_data;

  // Tap coordinates and linear RAM address from the registered counters
  always_comb begin
    row_pos  = int'(wr) * STRIDE + int'(kr) - ORG;
    col_pos  = int'(wc) * STRIDE + int'(kc) - ORG;
    lin      = int'(base) + row_pos * IMG_W + col_pos;
    lin_addr = ADDR_WIDTH'(lin);
  end

`ifdef INPUT_WINDOW_PAD_EN
  logic                  oob;
  logic [ADDR_WIDTH-1:0] last_addr;

  // Border taps read as zero and leave the RAM address where it was
  always_comb begin
    oob      = (row_pos < 0) || (row_pos >= IMG_H) || (col_pos < 0) || (col_pos >= IMG_W);
    tap_data = oob ? '0 : ram_data;
    if (state != ST_RUN) begin
      ram_addr = base;
    end else if (oob) begin
      ram_addr = last_addr;
    end else begin
      ram_addr = lin_addr;
    end
  end

  // Remember the address presented last cycle so border taps can hold it
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      last_addr <= '0;
    end else begin
      last_addr <= ram_addr;
    end
  end
`else
  // No border: every tap is a real RAM read
  always_comb begin
    tap_data = ram_data;
    ram_addr = lin_addr;
  end
`endif

  assign load      = (state == ST_RUN) && !all_loaded && (!out_valid || out_ready);
  assign final_tap = (kc == K_LAST) && (kr == K_LAST) && (wc == NC_LAST) && (wr == NR_LAST);
  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);

  // Sweep control: run until the last tap has been handed downstream
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_IDLE;
      base  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            base  <= base_addr;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (all_loaded && out_valid && out_ready) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Tap counters: kc fastest, then kr, then wc, then wr; wrap to zero after the final tap
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      wr         <= '0;
      wc         <= '0;
      kr         <= '0;
      kc         <= '0;
      all_loaded <= 1'b0;
    end else if (state == ST_IDLE && start) begin
      wr         <= '0;
      wc         <= '0;
      kr         <= '0;
      kc         <= '0;
      all_loaded <= 1'b0;
    end else if (load) begin
      if (final_tap) begin
        all_loaded <= 1'b1;
      end
      if (kc == K_LAST) begin
        kc <= '0;
        if (kr == K_LAST) begin
          kr <= '0;
          if (wc == NC_LAST) begin
            wc <= '0;
            if (wr == NR_LAST) begin
              wr <= '0;
            end else begin
              wr <= wr + 8'd1;
            end
          end else begin
            wc <= wc + 8'd1;
          end
        end else begin
          kr <= kr + 8'd1;
        end
      end else begin
        kc <= kc + 8'd1;
      end
    end
  end

  // One-entry output register; holds its contents while downstream stalls
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_first <= 1'b0;
      out_last  <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= tap_data;
      out_first <= (kr == 8'd0) && (kc == 8'd0);
      out_last  <= (kr == K_LAST) && (kc == K_LAST);
      win_row   <= wr;
      win_col   <= wc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_input_window_sched.sv
// tb/tb_input_window_sched.sv - directed-vector bench for input_window_sched
module tb_input_window_sched;

`ifdef INPUT_WINDOW_PAD_EN
  localparam int NWIN = 8;
  localparam int PADV = 1;
`else
  localparam int NWIN = 6;
  localparam int PADV = 0;
`endif
  localparam int NBEATS = NWIN * NWIN * 9;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       start = 1'b0;
  logic [9:0] base_addr = '0;
  logic       busy, done;
  logic [9:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_first, out_last;
  logic [7:0] win_row, win_col;

  logic [7:0] mem [1024];
  assign ram_data = mem[ram_addr];

  input_window_sched dut (
    .Clk(Clk), .Reset(Reset), .start(start), .base_addr(base_addr),
    .busy(busy), .done(done), .ram_addr(ram_addr), .ram_data(ram_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_first(out_first), .out_last(out_last), .win_row(win_row), .win_col(win_col)
  );

  always #5 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int nbeats = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int last_acc_cyc = 0;
  logic [25:0] q_beat [$];
  logic [26:0] held = '0;
  bit prev_stall = 1'b0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [25:0] model_beat(input int b, input int n);
    int t, w, r, c, a;
    logic [7:0] d;
    t = n % 9;
    w = n / 9;
    r = (w / NWIN) + t / 3 - PADV;
    c = (w % NWIN) + t % 3 - PADV;
    a = (b + r * 8 + c) & 1023;
    d = (r < 0 || r >= 8 || c < 0 || c >= 8) ? 8'd0 : mem[a];
    return {t == 0, t == 8, d, 8'(w / NWIN), 8'(w % NWIN)};
  endfunction

  always @(posedge Clk) cyc++;

  // Beat collector and stall-stability watcher, sampled mid-cycle
  always @(negedge Clk) begin
    logic [26:0] cur;
    cur = {out_valid, out_first, out_last, out_data, win_row, win_col};
    if (prev_stall && !Reset) check_val("stall_hold", 32'(cur), 32'(held));
    prev_stall = out_valid && !out_ready && !Reset;
    held = cur;
    if (out_valid && out_ready) begin
      q_beat.push_back(cur[25:0]);
      nbeats++;
      last_acc_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  task automatic begin_sweep(input int b, input int tap4_addr);
    q_beat.delete();
    nbeats = 0;
    done_cnt = 0;
    out_ready = 1'b1;
    @(posedge Clk); #1;
    base_addr = 10'(b);
    start = 1'b1;
    @(posedge Clk); #1;
    start = 1'b0;
    base_addr = 10'(~b);
    check_val("busy_after_start", 32'(busy), 1);
    check_val("valid_not_yet", 32'(out_valid), 0);
    check_val("addr_tap0", 32'(ram_addr), 32'(b & 1023));
    @(posedge Clk); #1;
    check_val("first_valid", 32'(out_valid), 1);
    repeat (3) @(posedge Clk);
    #1;
    check_val("addr_tap4", 32'(ram_addr), 32'(tap4_addr));
  endtask

  task automatic run_sweep(input int b, input int mode, input int tap4_addr);
    int drop, errs;
    drop = 0;
    errs = 0;
    begin_sweep(b, tap4_addr);
    for (int i = 0; i < 4000 && done_cnt == 0; i++) begin
      out_ready = 1'b1;
      if (mode == 1) begin
        if (nbeats >= 40 && drop < 5) begin
          out_ready = 1'b0;
          drop++;
        end else if (nbeats >= 100 && nbeats <= 150) begin
          out_ready = i[0];
        end
      end
      start = (mode == 2) && (i >= 50) && (i < 53);
      @(posedge Clk); #1;
    end
    start = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    check_val("done_seen", 32'(done_cnt != 0), 1);
    check_val("beat_count", 32'(nbeats), 32'(NBEATS));
    check_val("done_pulses", 32'(done_cnt), 1);
    check_val("done_timing", 32'(done_cyc), 32'(last_acc_cyc + 1));
    check_val("idle_busy", 32'(busy), 0);
    for (int n = 0; n < q_beat.size() && n < NBEATS; n++) begin
      if (q_beat[n] !== model_beat(b, n)) errs++;
    end
    check_val("seq_errs", 32'(errs), 0);
  endtask

  initial begin
    logic [7:0] w00 [9];
    logic [7:0] w55 [9];
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i);
`ifdef INPUT_WINDOW_PAD_EN
    w00 = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd8, 8'd9};
`else
    w00 = '{8'd0, 8'd1, 8'd2, 8'd8, 8'd9, 8'd10, 8'd16, 8'd17, 8'd18};
    w55 = '{8'd45, 8'd46, 8'd47, 8'd53, 8'd54, 8'd55, 8'd61, 8'd62, 8'd63};
`endif

    #1;
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_done", 32'(done), 0);
    check_val("rst_valid", 32'(out_valid), 0);
    check_val("rst_data", 32'(out_data), 0);
    check_val("rst_tags", 32'({out_first, out_last, win_row, win_col}), 0);
    check_val("rst_addr", 32'(ram_addr), 0);
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b0;

    // Basic sweep, base 0, ready held high
    run_sweep(0, 0, PADV ? 0 : 9);
    if (q_beat.size() >= NBEATS) begin
      for (int t = 0; t < 9; t++) check_val("w00_data", 32'(q_beat[t][23:16]), 32'(w00[t]));
      check_val("w00_first", 32'(q_beat[0][25]), 1);
      check_val("w00_last", 32'(q_beat[8][24]), 1);
      check_val("w00_mid_tags", 32'({q_beat[4][25], q_beat[4][24]}), 0);
`ifdef INPUT_WINDOW_PAD_EN
      check_val("w77_last_data", 32'(q_beat[NBEATS-1][23:16]), 0);
      check_val("w77_pos", 32'(q_beat[NBEATS-1][15:0]), 32'({8'd7, 8'd7}));
`else
      for (int t = 0; t < 9; t++) check_val("w55_data", 32'(q_beat[315 + t][23:16]), 32'(w55[t]));
      check_val("w55_pos", 32'(q_beat[315][15:0]), 32'({8'd5, 8'd5}));
`endif
    end

    // Backpressure: 5-cycle stall at beat 40, toggling ready over beats 100-150
    run_sweep(0, 1, PADV ? 0 : 9);

    // Address wrap
    run_sweep(1020, 0, PADV ? 1020 : 5);
    if (q_beat.size() >= NBEATS) begin
      check_val("wrap_tap0", 32'(q_beat[0][23:16]), PADV ? 0 : 252);
      check_val("wrap_tap4", 32'(q_beat[4][23:16]), PADV ? 252 : 5);
    end

    // Start requests while running are ignored
    run_sweep(0, 2, PADV ? 0 : 9);

    // Reset at beat 200
    begin_sweep(0, PADV ? 0 : 9);
    for (int i = 0; i < 1000 && nbeats < 200; i++) begin
      @(posedge Clk); #1;
    end
    check_val("reached_200", 32'(nbeats), 200);
    Reset = 1'b1;
    #1;
    check_val("midrst_valid", 32'(out_valid), 0);
    check_val("midrst_busy", 32'(busy), 0);
    check_val("midrst_data", 32'(out_data), 0);
    check_val("midrst_addr", 32'(ram_addr), 0);
    @(posedge Clk); #1;
    Reset = 1'b0;
    repeat (20) @(posedge Clk);
    #1;
    check_val("midrst_no_done", 32'(done_cnt), 0);
    check_val("midrst_no_beats", 32'(nbeats), 200);

    // Clean sweep after reset
    run_sweep(0, 0, PADV ? 0 : 9);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/input_window_sched.md
# input_window_sched

Sequencer for the input feature-map RAM (10-bit address, 8-bit data, combinational read). On `start`, it sweeps a K×K convolution window across an IMG_H×IMG_W row-major feature map held in that RAM. It drives the RAM address and streams each tap value to the downstream MAC/fire-module datapath over a valid/ready handshake. Per-beat window position and first/last-tap markers are provided for accumulator control.

## Interface
- `ADDR_WIDTH`, 10: RAM address width.
- `DATA_WIDTH`, 8: RAM/stream data width.
- `IMG_W`, 8: feature-map width in pixels.
- `IMG_H`, 8: feature-map height in pixels.
- `K`, 3: window size (K×K taps).
- `STRIDE`, 1: window step in both dimensions.
- Reset is asynchronous and active-high. The block runs on one clock.
- `Clk` in 1: sole clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state immediately.
- `start` in 1: single-cycle request to begin a sweep; sampled only in IDLE.
- `base_addr` in ADDR_WIDTH: RAM address of pixel (0,0); captured when `start` is accepted.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse after the final beat is accepted.
- `ram_addr` out ADDR_WIDTH: address to the input RAM.
- `ram_data` in DATA_WIDTH: RAM read data, valid in the same cycle as `ram_addr`.
- `out_data` out DATA_WIDTH: tap value.
- `out_valid` out 1: `out_data` and tags are valid.
- `out_ready` in 1: downstream accepts the beat when `out_valid && out_ready`.
- `out_first` out 1: beat is tap (0,0) of its window.
- `out_last` out 1: beat is tap (K-1,K-1) of its window.
- `win_row` out 8: window row index of the current beat.
- `win_col` out 8: window column index of the current beat.

## Operation
- State machine:
  - IDLE → RUN on `start`.
  - RUN → DONE when the final tap is loaded and the output register drains (final beat accepted).
  - DONE → IDLE unconditionally after one cycle; `done` is high in DONE only.
- Counters `wr`, `wc`, `kr`, `kc` select the current tap.
  - Order: taps row-major within a window (`kc` fastest, then `kr`); windows row-major (`wc`, then `wr`).
- Number of windows per dimension:
  - Without padding: NR = (IMG_H-K)/STRIDE+1 and NC = (IMG_W-K)/STRIDE+1 (6×6 at defaults).
- Tap address computation:
  - r = wr·STRIDE+kr, c = wc·STRIDE+kc.
  - `ram_addr` = (base + r·IMG_W + c) mod 2^ADDR_WIDTH; wrap-around is allowed and silent.
  - `ram_addr` is combinational from the registered counters.
- Output register (one entry):
  - Loads {`ram_data`, tags} and advances the counters when in RUN, taps remain, and (`!out_valid || out_ready`).
  - Under `out_ready` = 0, `out_data` and all tags hold stable.
- `out_valid` clears on acceptance when no new tap is loaded.
- `start` in RUN or DONE is ignored. `base_addr` changes after acceptance have no effect.
- Idle outputs: `ram_addr` = captured base; counters are zero.

## Timing
- Reset values: `busy`=0, `done`=0, `out_valid`=0, `out_data`=0, `out_first`=0, `out_last`=0, `win_row`=0, `win_col`=0, `ram_addr`=0, state IDLE.
- Latency:
  - `start` high at edge N → `busy` high after N.
  - First `out_valid` after edge N+1.
- With `out_ready` held high, one beat per cycle; no bubbles within or between windows.
- Total beats: NR·NC·K² (324 at defaults). `done` pulses the cycle after the last acceptance.
- `Reset` asserted mid-sweep: all outputs return to reset values immediately. No further beats are emitted and `done` does not pulse.

## Configuration
- `INPUT_WINDOW_PAD_EN` defined:
  - Adds a zero border of width (K-1)/2, so NR = ceil(IMG_H/STRIDE) and NC = ceil(IMG_W/STRIDE) (8×8 windows, 576 beats at defaults).
  - r and c are offset by -(K-1)/2.
  - Out-of-bounds taps emit `out_data`=0 with normal tags, and `ram_addr` holds its previous value for those taps.
- Undefined: no padding logic is present; behaviour is as in Operation.

## Test plan
- Basic sweep:
  - Stimulus: RAM[i]=i[7:0], base 0, `out_ready`=1, `start`.
  - Required:
    - Window (0,0) emits 0,1,2,8,9,10,16,17,18, with `out_first` on 0 and `out_last` on 18.
    - Window (5,5) emits 45,46,47,53,54,55,61,62,63.
    - Exactly 324 beats, then one `done` pulse.
- Backpressure:
  - Stimulus: drop `out_ready` for 5 cycles at beat 40, and toggle it every cycle for beats 100–150.
  - Required: `out_data` and tags stable while stalled; beat sequence identical to the basic sweep; no loss or duplication.
- Address wrap:
  - Stimulus: base 1020.
  - Required: tap (0,0) of window (0,0) reads address 1020, and tap (1,1) reads (1020+9) mod 1024 = 5.
- Start and reset:
  - `start` during RUN is ignored and the beat count is still 324.
  - `Reset` at beat 200 gives `out_valid`=0 immediately and no `done`.
  - A new `start` afterwards produces a clean full sweep.
- Padding (`INPUT_WINDOW_PAD_EN`):
  - Window (0,0) emits 0,0,0,0,RAM[0],RAM[1],0,RAM[8],RAM[9].
  - Window (7,7) last tap is 0.
  - Exactly 576 beats.
